// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } bcd_state_t;

  // floor(w * log10(2)) + 1, using 0.30103 as a fixed-point approximation of log10(2)
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3, one bit per clock) with start/busy/done.
// Optional two's-complement input: define BIN2BCD_SIGNED_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = bcd_digits(WIDTH)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [WIDTH-1:0]                 bin_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [4*DIGITS-1:0]              bcd_o,
  output logic [$clog2(DIGITS+1)-1:0]      sig_digits_o,
  output logic                             neg_o
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned SregW = BcdW + WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam int unsigned SigW  = $clog2(DIGITS + 1);

  bcd_state_t        state_q, state_d;
  logic [SregW-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [SigW-1:0]   sig_q, sig_d;
  logic              done_q, done_d;

  logic [BcdW-1:0]   adj;
  logic [SregW-1:0]  shifted;
  logic [BcdW-1:0]   shifted_bcd;
  logic [SigW-1:0]   sig_scan;
  logic [WIDTH-1:0]  mag;
  logic              accept;
  logic              last;

  assign accept = (state_q == StIdle) && start_i;
  assign last   = (state_q == StShift) && (cnt_q == CntW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .digit_i (sreg_q[WIDTH + 4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign shifted     = {adj, sreg_q[WIDTH-1:0]} << 1;
  assign shifted_bcd = shifted[SregW-1 -: BcdW];

  // Highest non-zero digit wins; zero reports one significant digit.
  always_comb begin
    sig_scan = SigW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted_bcd[4*k +: 4] != 4'd0) begin
        sig_scan = SigW'(k + 1);
      end
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  logic neg_pend_q;
  logic neg_q;

  // Unsigned negation keeps the most-negative value correct (e.g. -128 -> 128).
  always_comb begin
    mag = bin_i[WIDTH-1] ? (~bin_i + 1'b1) : bin_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (accept) neg_pend_q <= bin_i[WIDTH-1];
      if (last)   neg_q      <= neg_pend_q;
    end
  end

  assign neg_o = neg_q;
`else
  assign mag   = bin_i;
  assign neg_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StShift;
      StShift: if (last)    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    sig_d  = sig_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sreg_d = {{BcdW{1'b0}}, mag};
          cnt_d  = CntW'(WIDTH);
        end
      end
      StShift: begin
        sreg_d = shifted;
        cnt_d  = cnt_q - CntW'(1);
        if (last) begin
          bcd_d  = shifted_bcd;
          sig_d  = sig_scan;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      sig_q  <= SigW'(1);
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      sig_q  <= sig_d;
      done_q <= done_d;
    end
  end

  assign busy_o       = (state_q == StShift);
  assign done_o       = done_q;
  assign bcd_o        = bcd_q;
  assign sig_digits_o = sig_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised and directed checks of bin2bcd_seq (WIDTH=8 and WIDTH=16) against a decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8, neg8;
  logic [11:0] bcd8;
  logic [1:0]  sig8;

  logic        start16 = 1'b0;
  logic [15:0] bin16 = '0;
  logic        busy16, done16, neg16;
  logic [19:0] bcd16;
  logic [2:0]  sig16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8)) u_dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start8),
    .bin_i        (bin8),
    .busy_o       (busy8),
    .done_o       (done8),
    .bcd_o        (bcd8),
    .sig_digits_o (sig8),
    .neg_o        (neg8)
  );

  bin2bcd_seq #(.WIDTH(16)) u_dut16 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start16),
    .bin_i        (bin16),
    .busy_o       (busy16),
    .done_o       (done16),
    .bcd_o        (bcd16),
    .sig_digits_o (sig16),
    .neg_o        (neg16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: magnitude by arithmetic, digits by repeated /10.
  function automatic logic [63:0] ref_bcd(input logic [63:0] v, input int w,
                                          output int sig, output bit n);
    logic [63:0] mag;
    logic [63:0] r;
    logic [63:0] d;
    mag = v & ((64'd1 << w) - 64'd1);
    n   = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (mag[w-1]) begin
      n   = 1'b1;
      mag = (64'd1 << w) - mag;
    end
`endif
    r   = '0;
    sig = 1;
    for (int k = 0; k < 16; k++) begin
      d   = mag % 10;
      r   = r | (d << (4 * k));
      if (d != 0) sig = k + 1;
      mag = mag / 10;
    end
    return r;
  endfunction

  // Call at a negedge with the 8-bit DUT idle or in its done cycle.
  task automatic conv8(input logic [7:0] v);
    logic [63:0] e;
    int s;
    bit n;
    int cyc;
    e = ref_bcd({56'd0, v}, 8, s, n);
    start8 = 1'b1;
    bin8   = v;
    @(negedge clk);
    start8 = 1'b0;
    bin8   = 8'($urandom);
    check_eq("busy8_after_accept", {63'd0, busy8}, 64'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done8 && cyc < 40);
    check_eq("latency8", 64'(cyc), 64'd8);
    check_eq("bcd8", {52'd0, bcd8}, e);
    check_eq("sig8", {62'd0, sig8}, 64'(s));
    check_eq("neg8", {63'd0, neg8}, {63'd0, n});
    check_eq("busy8_at_done", {63'd0, busy8}, 64'd0);
  endtask

  task automatic conv16(input logic [15:0] v);
    logic [63:0] e;
    int s;
    bit n;
    int cyc;
    e = ref_bcd({48'd0, v}, 16, s, n);
    start16 = 1'b1;
    bin16   = v;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done16 && cyc < 60);
    check_eq("latency16", 64'(cyc), 64'd16);
    check_eq("bcd16", {44'd0, bcd16}, e);
    check_eq("sig16", {61'd0, sig16}, 64'(s));
    check_eq("neg16", {63'd0, neg16}, {63'd0, n});
  endtask

  initial begin
    int ndone;
    logic [11:0] seen_bcd;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy8", {63'd0, busy8}, 64'd0);
    check_eq("rst_done8", {63'd0, done8}, 64'd0);
    check_eq("rst_bcd8", {52'd0, bcd8}, 64'd0);
    check_eq("rst_sig8", {62'd0, sig8}, 64'd1);
    check_eq("rst_neg8", {63'd0, neg8}, 64'd0);
    check_eq("rst_sig16", {61'd0, sig16}, 64'd1);

    // Back-to-back directed values, each started in the previous done cycle.
    conv8(8'd0);
    conv8(8'd10);
    conv8(8'd250);
    conv8(8'd137);
    conv8(8'h80);
    conv8(8'hFF);
    conv8(8'h7F);
    @(negedge clk);
    check_eq("done8_one_cycle", {63'd0, done8}, 64'd0);

    // Start while busy must be ignored.
    start8 = 1'b1;
    bin8   = 8'd255;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    ndone    = 0;
    seen_bcd = '0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        ndone++;
        seen_bcd = bcd8;
      end
      if (ndone == 1 && done8 && i < 19) begin
        // Accept a new operand in the done cycle.
        start8 = 1'b1;
        bin8   = 8'd99;
        @(negedge clk);
        start8 = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check_eq("ignore_ndone", 64'(ndone), 64'd1);
    check_eq("ignore_bcd", {52'd0, seen_bcd}, 64'h255);
    ndone = 0;
    for (int i = 1; i <= 20 && !done8; i++) begin
      @(negedge clk);
      ndone = i;
    end
    check_eq("b2b_latency", 64'(ndone), 64'd8);
    check_eq("b2b_bcd", {52'd0, bcd8}, 64'h099);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start8 = 1'b1;
    bin8   = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {63'd0, busy8}, 64'd0);
    check_eq("midrst_bcd", {52'd0, bcd8}, 64'd0);
    check_eq("midrst_sig", {62'd0, sig8}, 64'd1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check_eq("midrst_no_done", 64'(ndone), 64'd0);

    conv16(16'hFFFF);
    conv16(16'd0);
    conv16(16'h8000);
    for (int i = 0; i < 8; i++) conv16(16'($urandom));

    @(negedge clk);
    for (int i = 0; i < 40; i++) conv8(8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, multi-cycle binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake. It sits between the calculator ALU result and the seven-segment driver and replaces the fixed 8-bit, three-digit converter with one of any width. It also reports the significant-digit count so the display can blank leading zeros.

## Interface
- WIDTH, 8: binary input width (≥ 1).
- DIGITS, bcd_pkg::bcd_digits(WIDTH): BCD digit count, floor(WIDTH·log10 2)+1; WIDTH=8 gives 3, WIDTH=16 gives 5. Not to be overridden.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of bin; accepted only when busy=0.
- bin  in  WIDTH  binary operand; sampled on the accepting edge only.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd/sig_digits/neg valid from this cycle.
- bcd  out  4·DIGITS  result; digit k at [4k+3:4k], digit 0 = ones.
- sig_digits  out  $clog2(DIGITS+1)  index of highest non-zero digit +1; 1 for value 0.
- neg  out  1  result sign (see Configuration).

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: on start=1, load shift register {scratch BCD = 0, bin magnitude}, set count = WIDTH, busy←1, go to SHIFT. With start=0, stay in IDLE.
- SHIFT, each cycle:
  - Add 3 to every scratch digit ≥ 5.
  - Shift the whole register left by 1.
  - Decrement count.
- SHIFT, on the edge where count goes 1→0:
  - Write the adjusted-and-shifted scratch to bcd.
  - Compute sig_digits from that value; latch neg.
  - done←1, busy←0, go to IDLE.
- bcd, sig_digits and neg hold until the next completion.
- start while busy: ignored; the operand is not queued.
- Reset (any state, including mid-conversion): state IDLE, busy=0, done=0, bcd=0, sig_digits=1, neg=0, scratch cleared.
- Arithmetic: the scratch is 4·DIGITS bits and never overflows for a WIDTH-bit unsigned magnitude.

## Timing
- Start accepted at edge E0; busy high from E0.
- Shifts happen at E1…E_WIDTH.
- bcd and done update at E_WIDTH. Latency is WIDTH cycles from the accepting edge to done; WIDTH=8 gives 8.
- done is high for exactly one cycle, E_WIDTH to E_WIDTH+1.
- In the done cycle busy=0, so start in that cycle is accepted. Throughput is one conversion per WIDTH+1 cycles (back-to-back).
- WIDTH=1: a single SHIFT cycle; done at E1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - bin is two's complement.
  - Magnitude = bin[WIDTH-1] ? −bin : bin, taken as WIDTH-bit unsigned, so the most-negative value converts correctly (WIDTH=8: −128 → 128).
  - neg latches bin[WIDTH-1] at the accepting edge and is presented with done.
- Not defined:
  - bin is unsigned.
  - neg is constant 0; no negation logic is synthesised.
- Port list is identical in both builds.

## Structure
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - Function bcd_digits(int w).
  - FSM state enum bcd_state_t.
- Sub-module bcd_add3 (combinational, one digit: out = in ≥ 5 ? in + 3 : in), instantiated DIGITS times by generate.
- Significant-digit count is a priority scan inside the top module.

## Test plan
- WIDTH=8, reset, start with bin=0 → done 8 cycles later, bcd=12'h000, sig_digits=1, busy low after done.
- WIDTH=8, bin=10, then 250, then 137 → bcd 12'h010 / 12'h250 / 12'h137, sig_digits 2/3/3.
- WIDTH=8: start with bin=255, then pulse start with bin=7 at cycle 3 → bin=7 ignored; single done with bcd=12'h255. Start asserted in the done cycle with bin=99 → accepted; done 8 cycles later, bcd=12'h099.
- WIDTH=8: rst asserted at cycle 4 of a conversion → next cycle busy=0, bcd=0, sig_digits=1; no done pulse for that conversion.
- WIDTH=16, bin=65535 → done after 16 cycles, bcd=20'h65535, sig_digits=5.
- WIDTH=8, BIN2BCD_SIGNED_EN defined:
  - bin=8'h80 → neg=1, bcd=12'h128.
  - bin=8'hFF → neg=1, bcd=12'h001.
  - bin=8'h7F → neg=0, bcd=12'h127.
